// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Program-counter register and instruction-fetch sequencer. Issues one
// instruction-memory read per instruction (at most one outstanding), holds
// the fetched word for decode, and loads pc_next when decode accepts it.
//
// Optional build macro: FETCH_PERF_CNT_EN adds perf_fetch_cnt/perf_stall_cnt.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   pc_next           next PC from next_pc_mux, loaded on decode handshake
//   flush, flush_pc   redirect request and target (highest priority)
//   imem_req_*        fetch request channel (valid/ready, addr = current PC)
//   imem_rsp_*        fetch response channel (valid only, no backpressure)
//   if_valid, if_ready, if_instr, if_pc, if_pc_plus4   decode interface
//   perf_fetch_cnt, perf_stall_cnt   (FETCH_PERF_CNT_EN only)
//
// state | meaning
// REQ   | request at PC is presented to memory
// WAIT  | request accepted, waiting for the response
// HOLD  | instruction held for decode until accepted or flushed
// DROP  | flushed while a response is in flight; discard it when it lands
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_next,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    imem_req_valid = 1'b0;
    if_valid       = 1'b0;
    case (state_q)
      S_REQ: begin
        imem_req_valid = !flush;
        if (flush) begin
          pc_d = flush_pc & ALIGN_MASK;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          pc_d = flush_pc & ALIGN_MASK;
          // A response landing with the flush is the one outstanding read,
          // so nothing is left to drain.
          state_d = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if_valid = 1'b1;
        if (flush) begin
          pc_d    = flush_pc & ALIGN_MASK;
          state_d = S_REQ;
        end else if (if_ready) begin
          pc_d    = pc_next & ALIGN_MASK;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (flush) begin
          pc_d = flush_pc & ALIGN_MASK;
        end
        if (imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    // Outputs are quiet during the reset cycle regardless of the held state.
    if (rst) begin
      imem_req_valid = 1'b0;
      if_valid       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_VECTOR;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_req_addr = pc_q;
  assign if_pc         = pc_q;
  assign if_pc_plus4   = pc_q + 32'd4;
  assign if_instr      = instr_q;

`ifdef FETCH_PERF_CNT_EN
  logic        perf_retire;
  logic        perf_stall;
  logic [31:0] perf_fetch_q, perf_stall_q;

  assign perf_retire = (state_q == S_HOLD) && if_ready && !flush;
  assign perf_stall  = ((state_q == S_HOLD) && !if_ready) ||
                       (state_q == S_WAIT) || (state_q == S_DROP);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      if (perf_retire) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (perf_stall)  perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios followed by a randomized run.
// A memory model answers requests with an address-derived word after a
// random latency; the reference model only tracks which PC the next retired
// instruction must come from (last redirect target or chosen pc_next).
module tb_pc_fetch_unit;

  localparam logic [31:0] RV   = 32'h0000_1000;
  localparam logic [31:0] MASK = 32'hFFFF_FFFC;

  logic        clk;
  logic        rst;
  logic [31:0] pc_next;
  logic        flush;
  logic [31:0] flush_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  pc_fetch_unit #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst(rst), .pc_next(pc_next), .flush(flush), .flush_pc(flush_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int retires = 0;

  logic [31:0] exp_q[$];

  // stimulus knobs
  bit          rst_k = 1'b1;
  bit          flush_k = 1'b0;
  logic [31:0] flush_pc_k = '0;
  bit          pcn_force_en = 1'b0;
  logic [31:0] pcn_force = '0;
  int p_ready = 100, p_ifready = 100, p_flush = 0, p_branch = 0;
  int lat_min = 1, lat_max = 1;

  // memory model state
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          lat_cnt = 0;

  bit          acc;
  logic [31:0] acc_addr;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h0050_0093;
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  task automatic step();
    logic [31:0] model_pc;
    @(negedge clk);
    rst = rst_k;
    if (pend && lat_cnt == 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr);
      pend = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (pend) lat_cnt--;
    end
    imem_req_ready = ($urandom_range(99) < p_ready);
    if_ready       = ($urandom_range(99) < p_ifready);
    flush          = flush_k || ($urandom_range(999) < p_flush);
    if (flush_k)                      flush_pc = flush_pc_k;
    else if ($urandom_range(7) == 0)  flush_pc = 32'hFFFF_FFFC | 32'($urandom_range(3));
    else                              flush_pc = $urandom;
    model_pc = (exp_q.size() > 0) ? exp_q[0] : 32'd0;
    if (pcn_force_en)                        pc_next = pcn_force;
    else if ($urandom_range(99) < p_branch)  pc_next = $urandom;
    else                                     pc_next = model_pc + 32'd4;
    #1;
    acc = 1'b0;
    if (rst) begin
      exp_q.delete();
      exp_q.push_back(RV);
      chk(!imem_req_valid, "rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk(!if_valid, "rst_if_valid", {31'd0, if_valid}, 32'd0);
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        acc      = 1'b1;
        acc_addr = imem_req_addr;
        chk(!pend, "one_outstanding", {31'd0, pend}, 32'd0);
        pend      = 1'b1;
        pend_addr = imem_req_addr;
        lat_cnt   = $urandom_range(lat_max, lat_min);
      end
      if (flush) begin
        exp_q.delete();
        exp_q.push_back(flush_pc & MASK);
      end else if (if_valid && if_ready) begin
        exp_q.push_back(pc_next & MASK);
        retires++;
      end
    end
  endtask

  task automatic wait_accept(input int max_steps);
    for (int i = 0; i < max_steps; i++) begin
      step();
      if (acc) break;
    end
    chk(acc, "accept_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic wait_valid(input int max_steps);
    for (int i = 0; i < max_steps; i++) begin
      step();
      if (if_valid) break;
    end
    chk(if_valid, "valid_timeout", {31'd0, if_valid}, 32'd1);
  endtask

  // Monitor: compares retired instructions and request addresses against the
  // scoreboard, and checks the HOLD-stability rules.
  bit          held = 1'b0;
  logic [31:0] h_instr, h_pc;
  always @(negedge clk) begin
    logic [31:0] front;
    logic [31:0] e;
    #2;
    if (rst) begin
      held = 1'b0;
    end else begin
      front = (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF;
      if (if_valid)
        chk(!imem_req_valid, "no_req_in_hold", {31'd0, imem_req_valid}, 32'd0);
      if (held) begin
        chk(if_valid, "hold_valid", {31'd0, if_valid}, 32'd1);
        chk(if_instr == h_instr, "hold_instr", if_instr, h_instr);
        chk(if_pc == h_pc, "hold_pc", if_pc, h_pc);
      end
      if (imem_req_valid && imem_req_ready)
        chk(imem_req_addr == front, "req_addr", imem_req_addr, front);
      if (if_valid && if_ready && !flush) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "sb_empty", if_pc, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk(if_pc == e, "retire_pc", if_pc, e);
          chk(if_instr == mem_word(e), "retire_instr", if_instr, mem_word(e));
          chk(if_pc_plus4 == e + 32'd4, "retire_plus4", if_pc_plus4, e + 32'd4);
        end
      end
      held    = if_valid && !if_ready && !flush;
      h_instr = if_instr;
      h_pc    = if_pc;
    end
  end

  int          n_acc;
  int          acc_c[3];
  logic [31:0] acc_a[3];

  initial begin
    rst = 1'b1; flush = 1'b0; flush_pc = '0; pc_next = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b0;
    acc = 1'b0; acc_addr = '0;
    acc_c = '{default: -1};
    acc_a = '{default: 32'hFFFF_FFFF};

    // reset, then back-to-back fetch with ideal memory and decode
    step(); step();
    rst_k = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (acc && n_acc < 3) begin
        acc_c[n_acc] = i;
        acc_a[n_acc] = acc_addr;
        n_acc++;
      end
    end
    chk(acc_a[0] == 32'h1000, "seq_addr0", acc_a[0], 32'h1000);
    chk(acc_a[1] == 32'h1004, "seq_addr1", acc_a[1], 32'h1004);
    chk(acc_a[2] == 32'h1008, "seq_addr2", acc_a[2], 32'h1008);
    chk(acc_c[0] == 0, "first_req_cycle", 32'(acc_c[0]), 32'd0);
    chk(acc_c[1] - acc_c[0] == 3, "req_spacing1", 32'(acc_c[1] - acc_c[0]), 32'd3);
    chk(acc_c[2] - acc_c[1] == 3, "req_spacing2", 32'(acc_c[2] - acc_c[1]), 32'd3);

    // decode stall on instr 0x00500093 at 0x40, then branch to 0x2002
    flush_k = 1'b1; flush_pc_k = 32'h0000_0040;
    step();
    flush_k = 1'b0;
    p_ifready = 0;
    wait_valid(20);
    chk(if_instr == 32'h0050_0093, "stall_instr", if_instr, 32'h0050_0093);
    for (int i = 0; i < 5; i++) step();
    chk(if_valid && if_pc == 32'h40, "stall_pc", if_pc, 32'h40);
    pcn_force_en = 1'b1; pcn_force = 32'h0000_2002; p_ifready = 100;
    step();
    pcn_force_en = 1'b0;
    wait_accept(10);
    chk(acc_addr == 32'h2000, "branch_addr", acc_addr, 32'h2000);

    // flush in WAIT without response; response lands two cycles later
    lat_min = 3; lat_max = 3;
    wait_accept(10);
    flush_k = 1'b1; flush_pc_k = 32'h0000_3000;
    step();
    flush_k = 1'b0;
    lat_min = 2; lat_max = 2;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      step();
      chk(!if_valid, "drop_no_valid", {31'd0, if_valid}, 32'd0);
    end
    chk(acc && acc_addr == 32'h3000, "drop_next_addr", acc_addr, 32'h3000);

    // flush coincident with the response in WAIT
    step();
    flush_k = 1'b1; flush_pc_k = 32'h0000_3100;
    step();
    flush_k = 1'b0;
    lat_min = 1; lat_max = 1;
    wait_accept(10);
    chk(acc_addr == 32'h3100, "wait_flush_addr", acc_addr, 32'h3100);

    // flush coincident with if_ready in HOLD
    step();
    flush_k = 1'b1; flush_pc_k = 32'h0000_3200;
    step();
    chk(if_valid, "hold_flush_valid", {31'd0, if_valid}, 32'd1);
    flush_k = 1'b0;
    wait_accept(10);
    chk(acc_addr == 32'h3200, "hold_flush_addr", acc_addr, 32'h3200);

    // PC wrap at the top of the address space (low bits of flush_pc dropped)
    flush_k = 1'b1; flush_pc_k = 32'hFFFF_FFFE;
    step();
    flush_k = 1'b0;
    wait_valid(20);
    chk(if_pc == 32'hFFFF_FFFC, "wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk(if_pc_plus4 == 32'd0, "wrap_plus4", if_pc_plus4, 32'd0);
    lat_min = 3; lat_max = 3;
    wait_accept(10);
    chk(acc_addr == 32'd0, "wrap_next_addr", acc_addr, 32'd0);

    // reset in the middle of WAIT; late response lands in REQ
    step();
    rst_k = 1'b1;
    step();
    rst_k = 1'b0;
    lat_min = 1; lat_max = 1;
    step();
    chk(imem_req_valid && imem_req_addr == RV, "post_rst_req", imem_req_addr, RV);
    chk(!if_valid, "post_rst_if_valid", {31'd0, if_valid}, 32'd0);

    // randomized traffic
    p_ready = 70; lat_min = 1; lat_max = 4; p_ifready = 60; p_flush = 30; p_branch = 20;
    for (int i = 0; i < 3000; i++) step();
    chk(retires > 100, "progress", 32'(retires), 32'd100);

    @(negedge clk);
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer; sits directly downstream of next_pc_mux.
- Holds the architectural PC and issues one instruction-memory read per instruction over a valid/ready request channel and a valid-only response channel.
- Presents the fetched instruction, its PC and PC+4 to decode; loads pc_next when decode accepts the instruction.
- Supplies if_pc_plus4 back to the mux's pc_plus4 input.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_next  in  32  next PC from next_pc_mux; sampled on decode handshake.
- flush  in  1  redirect request; highest priority in every state.
- flush_pc  in  32  redirect target; sampled when flush=1.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  fetch address (always the current PC).
- imem_rsp_valid  in  1  read data valid; no backpressure.
- imem_rsp_data  in  32  instruction word.
- if_valid  out  1  instruction held for decode.
- if_ready  in  1  decode/execute accepts (instruction retires).
- if_instr  out  32  captured instruction.
- if_pc  out  32  PC of if_instr.
- if_pc_plus4  out  32  if_pc + 4, modulo 2^32.

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset: pc=RESET_VECTOR, state=REQ, instr buffer=32'h0000_0013 (NOP).
  - During the reset cycle: imem_req_valid=0, if_valid=0.
  - First request issues the cycle after rst deasserts.
- States: REQ, WAIT, HOLD, DROP.
- Any loaded PC value (pc_next or flush_pc) has bits [1:0] forced to 2'b00.
- imem_req_addr=pc in all states. if_pc=pc. if_pc_plus4=pc+32'd4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
- REQ:
  - imem_req_valid = !flush (combinational).
  - flush: pc<=flush_pc; stay in REQ.
  - else if imem_req_ready: go to WAIT.
- WAIT:
  - imem_req_valid=0.
  - flush with imem_rsp_valid in the same cycle: discard data, pc<=flush_pc, go to REQ.
  - flush without imem_rsp_valid: pc<=flush_pc, go to DROP.
  - else if imem_rsp_valid: instr<=imem_rsp_data, go to HOLD.
- HOLD:
  - if_valid=1; if_instr, if_pc and if_pc_plus4 are stable while if_valid=1 and if_ready=0.
  - flush: pc<=flush_pc, go to REQ; if_ready in the same cycle is ignored and no retire is counted.
  - else if if_ready: pc<=pc_next, go to REQ.
- DROP:
  - imem_req_valid=0; waits for the single outstanding response.
  - imem_rsp_valid: discard, go to REQ.
  - flush: pc<=flush_pc; stay in DROP until the response arrives.
- if_valid is 1 only in HOLD.
- At most one outstanding request at any time.
- Minimum latency per instruction: 3 cycles (REQ accept, response, HOLD accept) when memory answers the cycle after acceptance and decode is ready.
- imem_rsp_valid in REQ or HOLD is a protocol violation and is ignored.
- rst asserted in any state, including mid-request: returns to the reset state next edge; any in-flight response arriving after reset is ignored if it lands in REQ.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both cleared by rst and wrapping at 2^32.
  - perf_fetch_cnt increments on each HOLD retire (if_ready=1, flush=0).
  - perf_stall_cnt increments each cycle in HOLD with if_ready=0, and each cycle in WAIT or DROP.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, RESET_VECTOR=32'h0000_1000, memory always ready with 1-cycle response, if_ready=1, pc_next=pc+4 -> requests at 0x1000, 0x1004, 0x1008 every 3 cycles; if_pc_plus4=0x1004 with the first instruction.
- Decode stall: hold if_ready=0 for 5 cycles in HOLD with instr 32'h00500093 -> if_valid, if_instr and if_pc stable; no new imem_req_valid until if_ready=1.
- Branch: pc_next=32'h0000_2002 on retire -> next imem_req_addr=32'h0000_2000.
- Flush in WAIT with no response, flush_pc=0x3000, response arrives 2 cycles later -> data discarded, if_valid stays 0, next request addr=0x3000.
- Flush coincident with imem_rsp_valid in WAIT, and flush coincident with if_ready in HOLD -> no instruction delivered or retired; next request uses flush_pc.
- pc=32'hFFFF_FFFC -> if_pc_plus4=0. rst mid-WAIT -> next cycle state REQ, pc=RESET_VECTOR, if_valid=0.
